osc_window_counter: RTL and testbench



---
 rtl/osc_window_counter_pkg.sv | 14 +
 rtl/osc_window_counter_bcd4_sat_counter.sv | 56 +++++
 rtl/osc_window_counter.sv | 130 +++++++++++++
 tb/tb_osc_window_counter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/osc_window_counter_pkg.sv
// Shared types and constants for the ring-oscillator gate-window counter.
package osc_window_counter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2,
    LATCH   = 2'd3
  } state_e;

  localparam logic [3:0]  BCD_MAX_DIGIT = 4'd9;
  localparam logic [15:0] BCD_SAT       = 16'h9999;

endpackage

// File: rtl/osc_window_counter_bcd4_sat_counter.sv
// Four-digit BCD up-counter that saturates at 9999 and flags any further increment.
module bcd4_sat_counter
  import osc_window_counter_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic        sync_clr,
  input  logic        inc,
  output logic [15:0] count,
  output logic        sat
);

  logic [15:0] count_q, count_d;
  logic        sat_q, sat_d;
  logic        carry;

  always_comb begin
    count_d = count_q;
    sat_d   = sat_q;
    carry   = 1'b1;
    if (sync_clr) begin
      count_d = '0;
      sat_d   = 1'b0;
    end else if (inc) begin
      if (count_q == BCD_SAT) begin
        sat_d = 1'b1;
      end else begin
        // Ripple the carry from the units digit upward.
        for (int i = 0; i < 4; i++) begin
          if (carry) begin
            if (count_q[4*i +: 4] == BCD_MAX_DIGIT) begin
              count_d[4*i +: 4] = 4'd0;
            end else begin
              count_d[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
              carry             = 1'b0;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      sat_q   <= sat_d;
    end
  end

  assign count = count_q;
  assign sat   = sat_q;

endmodule

// File: rtl/osc_window_counter.sv
// Debounced start, fixed gate window, BCD count of oscillator rising edges, latched result.
module osc_window_counter
  import osc_window_counter_pkg::*;
#(
  parameter int unsigned WINDOW          = 7000,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic        FPGA_clk,
  input  logic        clr,
  input  logic        start,
  input  logic        osc_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] bcd_out,
  output logic        overflow
);

  localparam int unsigned   DbW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0]   WinLast = 16'(WINDOW - 1);

  logic           start_s1, start_s2;
  logic           osc_s1, osc_s2, osc_s3;
  logic           osc_rise;
  logic           start_db_q;
  logic [DbW-1:0] db_cnt_q;
  logic           start_go_q;

  state_e         state_q, state_d;
  logic [15:0]    win_cnt_q, win_cnt_d;
  logic           cnt_clr, cnt_inc, latch;
  logic [15:0]    work_bcd;
  logic           work_sat;
  logic [15:0]    bcd_out_q;
  logic           overflow_q;

  assign osc_rise = osc_s2 & ~osc_s3;

  always_ff @(posedge FPGA_clk or negedge clr) begin
    if (!clr) begin
      start_s1   <= 1'b0;
      start_s2   <= 1'b0;
      osc_s1     <= 1'b0;
      osc_s2     <= 1'b0;
      osc_s3     <= 1'b0;
      start_db_q <= 1'b0;
      db_cnt_q   <= '0;
      start_go_q <= 1'b0;
    end else begin
      start_s1   <= start;
      start_s2   <= start_s1;
      osc_s1     <= osc_in;
      osc_s2     <= osc_s1;
      osc_s3     <= osc_s2;
      start_go_q <= 1'b0;
      if (start_s2 == start_db_q) begin
        db_cnt_q <= '0;
      end else if (db_cnt_q == DbLast) begin
        db_cnt_q   <= '0;
        start_db_q <= start_s2;
        start_go_q <= start_s2;
      end else begin
        db_cnt_q <= db_cnt_q + DbW'(1);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    win_cnt_d = win_cnt_q;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    latch     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_go_q) state_d = ARM;
      end
      ARM: begin
        busy      = 1'b1;
        cnt_clr   = 1'b1;
        win_cnt_d = '0;
        state_d   = MEASURE;
      end
      MEASURE: begin
        busy    = 1'b1;
        cnt_inc = osc_rise;
        if (win_cnt_q == WinLast) state_d = LATCH;
        else                      win_cnt_d = win_cnt_q + 16'd1;
      end
      LATCH: begin
        done    = 1'b1;
        latch   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge FPGA_clk or negedge clr) begin
    if (!clr) begin
      state_q    <= IDLE;
      win_cnt_q  <= '0;
      bcd_out_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_cnt_q <= win_cnt_d;
      // Result is visible from the cycle after the done pulse.
      if (latch) begin
        bcd_out_q  <= work_bcd;
        overflow_q <= work_sat;
      end
    end
  end

  bcd4_sat_counter u_count (
    .clk      (FPGA_clk),
    .clr      (clr),
    .sync_clr (cnt_clr),
    .inc      (cnt_inc),
    .count    (work_bcd),
    .sat      (work_sat)
  );

  assign bcd_out  = bcd_out_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_osc_window_counter.sv
// Bench: per-cycle model check of a short-window instance plus a saturation run on a long one.
module tb_osc_window_counter;

  localparam int WA = 100;
  localparam int DA = 4;
  localparam int WB = 30000;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        start_a = 1'b0, osc_a = 1'b0;
  logic        start_b = 1'b0, osc_b = 1'b0;
  logic        busy_a, done_a, ov_a, busy_b, done_b, ov_b;
  logic [15:0] bcd_a, bcd_b;

  int cyc = 0;
  int n_pass = 0, n_total = 0;
  int osc_half_a = 0, osc_half_b = 0, ph_a = 0, ph_b = 0;
  int done_cnt_a = 0, last_done_a = -1, done_cnt_b = 0, last_done_b = -1;

  osc_window_counter #(.WINDOW(WA), .DEBOUNCE_CYCLES(DA)) dut_a (
    .FPGA_clk (clk), .clr (clr), .start (start_a), .osc_in (osc_a),
    .busy (busy_a), .done (done_a), .bcd_out (bcd_a), .overflow (ov_a)
  );

  osc_window_counter #(.WINDOW(WB), .DEBOUNCE_CYCLES(DA)) dut_b (
    .FPGA_clk (clk), .clr (clr), .start (start_b), .osc_in (osc_b),
    .busy (busy_b), .done (done_b), .bcd_out (bcd_b), .overflow (ov_b)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total = n_total + 1;
    if (got === exp) n_pass = n_pass + 1;
    else $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, got, exp);
  endtask

  task automatic tick(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [15:0] to_bcd(input int c);
    int v;
    v = (c > 9999) ? 9999 : c;
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic int ix(input int k);
    return k & 15;
  endfunction

  // Oscillator sources: toggle every osc_half cycles, or hold low when zero.
  initial forever begin
    @(posedge clk);
    #1;
    if (osc_half_a == 0) begin osc_a = 1'b0; ph_a = 0; end
    else begin
      ph_a = ph_a + 1;
      if (ph_a >= osc_half_a) begin osc_a = ~osc_a; ph_a = 0; end
    end
    if (osc_half_b == 0) begin osc_b = 1'b0; ph_b = 0; end
    else begin
      ph_b = ph_b + 1;
      if (ph_b >= osc_half_b) begin osc_b = ~osc_b; ph_b = 0; end
    end
  end

  // Model of instance A: input histories, debounce by window scan, measurement by go-cycle offset.
  bit        h_in [16];
  bit        h_osc[16];
  bit        h_sync[16];
  bit        h_db [16];
  bit        m_active = 1'b0;
  int        m_t0 = 0, m_cnt = 0;
  logic [15:0] m_bcd = '0;
  bit        m_ov = 1'b0;

  initial forever begin
    bit sync, rise, db_prev, db, stable, go, e_busy, e_done;
    int n, k;
    @(negedge clk);
    n      = cyc;
    e_busy = 1'b0;
    e_done = 1'b0;
    if (!clr) begin
      h_in[ix(n)] = 1'b0; h_osc[ix(n)] = 1'b0; h_sync[ix(n)] = 1'b0; h_db[ix(n)] = 1'b0;
      m_active = 1'b0; m_bcd = '0; m_ov = 1'b0;
    end else begin
      h_in[ix(n)]  = start_a;
      h_osc[ix(n)] = osc_a;
      sync = h_in[ix(n - 2)];
      rise = h_osc[ix(n - 2)] & ~h_osc[ix(n - 3)];
      h_sync[ix(n)] = sync;
      db_prev = h_db[ix(n - 1)];
      stable  = 1'b1;
      for (int j = 1; j <= DA; j++) if (h_sync[ix(n - j)] == db_prev) stable = 1'b0;
      db = stable ? ~db_prev : db_prev;
      h_db[ix(n)] = db;
      go = db & ~db_prev;
      if (m_active) begin
        k = n - m_t0;
        if (k >= 2 && k <= WA + 1 && rise) m_cnt = m_cnt + 1;
        e_busy = (k >= 1 && k <= WA + 1);
        e_done = (k == WA + 2);
        if (k == WA + 3) begin
          m_bcd = to_bcd(m_cnt);
          m_ov  = (m_cnt > 9999);
          m_active = 1'b0;
        end
      end
      if (!m_active && go) begin
        m_active = 1'b1;
        m_t0 = n;
        m_cnt = 0;
      end
    end
    check("cycle_a", {13'd0, busy_a, done_a, ov_a, bcd_a}, {13'd0, e_busy, e_done, m_ov, m_bcd});
    if (done_a) begin done_cnt_a = done_cnt_a + 1; last_done_a = n; end
    if (done_b) begin done_cnt_b = done_cnt_b + 1; last_done_b = n; end
  end

  initial begin
    int p, c0;

    // Reset state
    tick(3);
    check("reset_busy", {31'd0, busy_a}, 32'd0);
    check("reset_bcd", {16'd0, bcd_a}, 32'h0);
    check("reset_ovf", {31'd0, ov_a | ov_b}, 32'd0);
    clr = 1'b1;
    tick(5);

    // Clean press held through the window: one measurement, 10 edges
    osc_half_a = 5;
    tick(3);
    c0 = done_cnt_a; start_a = 1'b1; p = cyc;
    tick(150);
    start_a = 1'b0;
    tick(10);
    check("clean_done_count", done_cnt_a - c0, 1);
    check("clean_latency", last_done_a - p, 108);
    check("clean_bcd", {16'd0, bcd_a}, 32'h0010);
    check("clean_ovf", {31'd0, ov_a}, 32'd0);

    // Bouncing press, then held high
    c0 = done_cnt_a;
    for (int i = 0; i < 20; i++) begin
      start_a = ((i % 4) < 2);
      tick(1);
    end
    start_a = 1'b1; p = cyc;
    tick(115);
    start_a = 1'b0;
    tick(10);
    check("bounce_done_count", done_cnt_a - c0, 1);
    check("bounce_latency", last_done_a - p, 108);

    // Silent oscillator, then a second press with edges
    osc_half_a = 0;
    tick(5);
    c0 = done_cnt_a; start_a = 1'b1;
    tick(115);
    start_a = 1'b0;
    tick(10);
    check("silent_done_count", done_cnt_a - c0, 1);
    check("silent_bcd", {16'd0, bcd_a}, 32'h0000);
    check("silent_ovf", {31'd0, ov_a}, 32'd0);
    osc_half_a = 5;
    tick(3);
    start_a = 1'b1;
    tick(50);
    check("held_mid_bcd", {16'd0, bcd_a}, 32'h0000);
    tick(65);
    start_a = 1'b0;
    check("second_bcd", {16'd0, bcd_a}, 32'h0010);
    tick(10);

    // Reset mid-measurement aborts without done
    start_a = 1'b1;
    tick(40);
    c0 = done_cnt_a; clr = 1'b0; start_a = 1'b0;
    tick(1);
    check("abort_busy", {31'd0, busy_a}, 32'd0);
    check("abort_bcd", {16'd0, bcd_a}, 32'h0);
    tick(2);
    clr = 1'b1;
    tick(3);
    check("abort_no_done", done_cnt_a - c0, 0);
    tick(5);
    start_a = 1'b1;
    tick(115);
    start_a = 1'b0;
    tick(10);
    check("after_abort_done", done_cnt_a - c0, 1);
    check("after_abort_bcd", {16'd0, bcd_a}, 32'h0010);

    // Re-press during MEASURE is ignored
    c0 = done_cnt_a; start_a = 1'b1; p = cyc;
    tick(30);
    start_a = 1'b0;
    tick(8);
    start_a = 1'b1;
    tick(30);
    start_a = 1'b0;
    tick(100);
    check("repress_done_count", done_cnt_a - c0, 1);
    check("repress_latency", last_done_a - p, 108);
    check("repress_idle", {31'd0, busy_a}, 32'd0);

    // Saturation on the long window: 15000 edges clamp to 9999
    osc_half_b = 1;
    tick(3);
    start_b = 1'b1; p = cyc;
    for (int i = 0; i < WB + 200 && done_cnt_b == 0; i++) tick(1);
    start_b = 1'b0;
    tick(3);
    check("sat_done_count", done_cnt_b, 1);
    check("sat_latency", last_done_b - p, WB + 8);
    check("sat_bcd", {16'd0, bcd_b}, 32'h9999);
    check("sat_ovf", {31'd0, ov_b}, 32'd1);
    check("sat_idle", {31'd0, busy_b}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
